// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 raster constants, colours and screen regions.
// Used by the timing generator and the pixel painter.
package vga_timing_pkg;

    localparam int CLK_DIV = 4;

    localparam logic [9:0] H_TOTAL     = 10'd800;
    localparam logic [9:0] H_SYNC      = 10'd96;
    localparam logic [9:0] H_VIS_START = 10'd144;
    localparam logic [9:0] H_VIS_END   = 10'd783;

    localparam logic [9:0] V_TOTAL     = 10'd525;
    localparam logic [9:0] V_SYNC      = 10'd2;
    localparam logic [9:0] V_VIS_START = 10'd35;
    localparam logic [9:0] V_VIS_END   = 10'd514;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] BLUE  = 12'h00F;

    localparam logic [9:0] GROUND_ROW  = 10'd475;
    localparam logic [9:0] EDGE_MARGIN = 10'd8;

    function automatic logic in_span(
        input logic [9:0] x,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_en_div.sv
// Clock-enable divider: one-clk strobe every DIV cycles of clk.
// The strobe decodes the registered count, so it is low in reset.
module pixel_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + W'(1);
        end
    end

    assign pix_en = (r_div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, syncs, bright and frame tick for the VGA output.
// Flags are registered from next-state counts, so they never skew.
import vga_timing_pkg::*;

module vga_timing_gen #(
    parameter int         CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter logic [9:0] H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter logic [9:0] H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter logic [9:0] H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter logic [9:0] H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter logic [9:0] V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter logic [9:0] V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter logic [9:0] V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter logic [9:0] V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       frame_tick
);

    logic       w_pix_en;
    logic       w_h_wrap;
    logic       w_frame_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hs;
    logic       r_vs;
    logic       r_br;
    logic       r_ft;

    pixel_en_div #(
        .DIV    (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .pix_en (w_pix_en)
    );

    // Out-of-range counts fall back to 0 on the next pixel.
    always_comb begin
        w_h_wrap     = (r_h >= H_TOTAL - 10'd1);
        w_h_next     = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next     = (r_v >= V_TOTAL) ? 10'd0 : r_v;
        w_frame_wrap = 1'b0;
        if (w_h_wrap) begin
            w_frame_wrap = (r_v >= V_TOTAL - 10'd1);
            w_v_next     = w_frame_wrap ? 10'd0 : r_v + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h  <= '0;
            r_v  <= '0;
            r_hs <= 1'b0;
            r_vs <= 1'b0;
            r_br <= 1'b0;
            r_ft <= 1'b0;
        end else begin
            r_ft <= 1'b0;
            if (w_pix_en) begin
                r_h  <= w_h_next;
                r_v  <= w_v_next;
                r_hs <= (w_h_next >= H_SYNC);
                r_vs <= (w_v_next >= V_SYNC);
                r_br <= in_span(w_h_next, H_VIS_START, H_VIS_END)
                     && in_span(w_v_next, V_VIS_START, V_VIS_END);
                r_ft <= w_frame_wrap;
            end
        end
    end

    assign pix_en     = w_pix_en;
    assign hCount     = r_h;
    assign vCount     = r_v;
    assign hSync      = r_hs;
    assign vSync      = r_vs;
    assign bright     = r_br;
    assign frame_tick = r_ft;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster for line timing,
// a shrunken raster for frame-level behaviour.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;

    logic       f_pix, f_br, f_hs, f_vs, f_ft;
    logic [9:0] f_h, f_v;
    logic       s_pix, s_br, s_hs, s_vs, s_ft;
    logic [9:0] s_h, s_v;

    int n_cmp = 0;
    int n_bad = 0;
    int kf = 0;
    int ks = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    vga_timing_gen dut_f (
        .clk        (clk),
        .reset      (rst_f),
        .pix_en     (f_pix),
        .hCount     (f_h),
        .vCount     (f_v),
        .bright     (f_br),
        .hSync      (f_hs),
        .vSync      (f_vs),
        .frame_tick (f_ft)
    );

    vga_timing_gen #(
        .CLK_DIV     (4),
        .H_TOTAL     (10'd20),
        .H_SYNC      (10'd3),
        .H_VIS_START (10'd5),
        .H_VIS_END   (10'd16),
        .V_TOTAL     (10'd12),
        .V_SYNC      (10'd2),
        .V_VIS_START (10'd3),
        .V_VIS_END   (10'd9)
    ) dut_s (
        .clk        (clk),
        .reset      (rst_s),
        .pix_en     (s_pix),
        .hCount     (s_h),
        .vCount     (s_v),
        .bright     (s_br),
        .hSync      (s_hs),
        .vSync      (s_vs),
        .frame_tick (s_ft)
    );

    // State expected k clk edges after reset release.
    function automatic exp_t model(int k, int ht, int vt, int hsn, int vsn,
                                   int hvs, int hve, int vvs, int vve);
        exp_t e;
        int p;
        int h;
        int v;
        p = k / 4;
        h = p % ht;
        v = (p / ht) % vt;
        e.pix = (k % 4 == 3);
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !(h < hsn);
        e.vs  = !(v < vsn);
        e.br  = (h >= hvs) && (h <= hve) && (v >= vvs) && (v <= vve);
        e.ft  = (k % 4 == 0) && (p > 0) && (p % (ht * vt) == 0);
        return e;
    endfunction

    function automatic exp_t model_f(int k);
        return model(k, 800, 525, 96, 2, 144, 783, 35, 514);
    endfunction

    function automatic exp_t model_s(int k);
        return model(k, 20, 12, 3, 2, 5, 16, 3, 9);
    endfunction

    task automatic reset_s();
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_s = 1'b0;
        ks = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        rst_f = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        got = {f_pix, f_h, f_v, f_hs, f_vs, f_br, f_ft};
        n_cmp++;
        if (got !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=0", got);
        end
        rst_f = 1'b0;
        kf = 0;
        for (int i = 1; i <= 12; i++) begin
            kf = i;
            sbq.push_back(model_f(kf));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {f_pix, f_h, f_v, f_hs, f_vs, f_br, f_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL release k=%0d got=%h want=%h", kf, got, e);
            end
            if (kf == 4) begin
                n_cmp++;
                if (f_h !== 10'd1) begin
                    n_bad++;
                    $display("FAIL first_pixel h=%0d want=1", f_h);
                end
            end
        end
    endtask

    task automatic test_horizontal();
        exp_t e;
        exp_t got;
        for (int i = 13; i <= 3210; i++) begin
            kf = i;
            sbq.push_back(model_f(kf));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {f_pix, f_h, f_v, f_hs, f_vs, f_br, f_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL line k=%0d got=%h want=%h", kf, got, e);
            end
            if (kf == 383 || kf == 384) begin
                n_cmp++;
                if (f_hs !== (kf == 384)) begin
                    n_bad++;
                    $display("FAIL hsync_edge k=%0d hs=%b h=%0d", kf, f_hs, f_h);
                end
            end
            if (kf == 3200) begin
                n_cmp++;
                if (f_h !== 10'd0 || f_v !== 10'd1) begin
                    n_bad++;
                    $display("FAIL line_wrap h=%0d v=%0d want 0,1", f_h, f_v);
                end
            end
        end
    endtask

    task automatic test_window();
        exp_t e;
        exp_t got;
        int nb;
        int nt;
        int th[6] = '{4, 17, 5, 5, 5, 16};
        int tv[6] = '{3, 3, 2, 10, 3, 9};
        logic tb_[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        nb = 0;
        nt = 0;
        reset_s();
        for (int i = 1; i <= 960; i++) begin
            ks = i;
            sbq.push_back(model_s(ks));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL window k=%0d got=%h want=%h", ks, got, e);
            end
            if (s_br) nb++;
            if (s_ft && ks < 960) nt++;
            for (int j = 0; j < 6; j++) begin
                if (ks % 4 == 0 && int'(e.h) == th[j] && int'(e.v) == tv[j]) begin
                    n_cmp++;
                    if (s_br !== tb_[j]) begin
                        n_bad++;
                        $display("FAIL bright_pt (%0d,%0d) got=%b want=%b",
                                 th[j], tv[j], s_br, tb_[j]);
                    end
                end
            end
        end
        n_cmp++;
        if (nb != 336) begin
            n_bad++;
            $display("FAIL bright_count got=%0d want=336", nb);
        end
        n_cmp++;
        if (nt != 0) begin
            n_bad++;
            $display("FAIL first_frame_tick got=%0d want=0", nt);
        end
    endtask

    task automatic test_vertical_frame();
        exp_t e;
        exp_t got;
        int nv;
        int nt;
        nv = 0;
        nt = 0;
        for (int i = 961; i <= 1928; i++) begin
            ks = i;
            sbq.push_back(model_s(ks));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL frame k=%0d got=%h want=%h", ks, got, e);
            end
            if (!s_vs && ks <= 1920) nv++;
            if (s_ft) begin
                nt++;
                n_cmp++;
                if (s_h !== 10'd0 || s_v !== 10'd0) begin
                    n_bad++;
                    $display("FAIL tick_pos h=%0d v=%0d want 0,0", s_h, s_v);
                end
            end
        end
        n_cmp++;
        if (nv != 160) begin
            n_bad++;
            $display("FAIL vsync_count got=%0d want=160", nv);
        end
        n_cmp++;
        if (nt != 1) begin
            n_bad++;
            $display("FAIL tick_count got=%0d want=1", nt);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        exp_t got;
        reset_s();
        for (int i = 1; i <= 521; i++) begin
            ks = i;
            sbq.push_back(model_s(ks));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL pre_reset k=%0d got=%h want=%h", ks, got, e);
            end
        end
        n_cmp++;
        if (s_h !== 10'd10 || s_v !== 10'd6) begin
            n_bad++;
            $display("FAIL mid_pos h=%0d v=%0d want 10,6", s_h, s_v);
        end
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        got = {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_ft};
        n_cmp++;
        if (got !== 25'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=%h want=0", got);
        end
        rst_s = 1'b0;
        ks = 0;
        for (int i = 1; i <= 12; i++) begin
            ks = i;
            sbq.push_back(model_s(ks));
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            got = {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_ft};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL restart k=%0d got=%h want=%h", ks, got, e);
            end
        end
    endtask

    task automatic test_alignment();
        logic ehs;
        logic evs;
        logic ebr;
        reset_s();
        for (int i = 1; i <= 1920; i++) begin
            @(posedge clk);
            #1;
            ehs = !(s_h < 10'd3);
            evs = !(s_v < 10'd2);
            ebr = (s_h >= 10'd5) && (s_h <= 10'd16)
               && (s_v >= 10'd3) && (s_v <= 10'd9);
            n_cmp++;
            if ({s_hs, s_vs, s_br} !== {ehs, evs, ebr}) begin
                n_bad++;
                $display("FAIL align h=%0d v=%0d got=%b%b%b want=%b%b%b",
                         s_h, s_v, s_hs, s_vs, s_br, ehs, evs, ebr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_window();
        test_vertical_frame();
        test_mid_reset();
        test_alignment();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
